cache_way_fill_writer: RTL and testbench

- Write-side counterpart of the 4-way read select path: picks one of 4 ways per set and steers fill data into it with a one-hot write enable.
- Keeps per-set tree pseudo-LRU state; hits and fills both update it.
- Sits between the miss/refill controller (upstream) and the per-way data/tag arrays (downstream).

---
 rtl/cache_way_fill_writer.sv | 148 ++++++++++++++
 tb/tb_cache_way_fill_writer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_way_fill_writer.sv
// ---------------------------------------------------------------------------
// cache_way_fill_writer
//   Write side of a 4-way set-associative cache. It picks a victim way for
//   each refill, using the lowest invalid way first and the per-set tree
//   pseudo-LRU otherwise. It then steers the fill data into that way with a
//   one-cycle, one-hot write enable.
//
// Ports
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_hit_valid/set/way  read-hit notification (one-hot way, lowest bit wins)
//   i_fill_valid/set/data, o_fill_ready   refill request handshake
//   i_way_valid        valid bits of the ways in i_fill_set
//   i_flush            synchronous clear of every PLRU bit
//   o_wr_en/set/data   per-way array write port (o_wr_en one-hot, 1 cycle)
//   o_victim_way       registered one-hot victim of the last accepted fill
//
// PLRU bits per set: [0]=b0 pair select (1=right), [1]=b1 (left pair,
// 1=way1), [2]=b2 (right pair, 1=way3). Only 4 ways are supported.
// ---------------------------------------------------------------------------
module cache_way_fill_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int INPUTS     = 4,
    parameter int SETS       = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_hit_valid,
    input  logic [$clog2(SETS)-1:0]  i_hit_set,
    input  logic [INPUTS-1:0]        i_hit_way,
    input  logic                     i_fill_valid,
    output logic                     o_fill_ready,
    input  logic [$clog2(SETS)-1:0]  i_fill_set,
    input  logic [DATA_WIDTH-1:0]    i_fill_data,
    input  logic [INPUTS-1:0]        i_way_valid,
    input  logic                     i_flush,
    output logic [INPUTS-1:0]        o_wr_en,
    output logic [$clog2(SETS)-1:0]  o_wr_set,
    output logic [DATA_WIDTH-1:0]    o_wr_data,
    output logic [INPUTS-1:0]        o_victim_way
);

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    state_t                   state, state_nxt;
    logic [SETS-1:0][2:0]     plru;

    logic                     hit_any;
    logic [1:0]               hit_idx;
    logic [2:0]               fill_base;
    logic [1:0]               victim_idx;
    logic [2:0]               fill_upd;
    logic                     accept;

    // lowest set bit of a 4-bit vector (caller guarantees non-zero)
    function automatic logic [1:0] first_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd3;
        if (v[2]) r = 2'd2;
        if (v[1]) r = 2'd1;
        if (v[0]) r = 2'd0;
        return r;
    endfunction

    // point the tree away from the way just accessed
    function automatic logic [2:0] plru_upd(input logic [2:0] b, input logic [1:0] w);
        logic [2:0] r;
        r = b;
        case (w)
            2'd0: begin r[0] = 1'b1; r[1] = 1'b1; end
            2'd1: begin r[0] = 1'b1; r[1] = 1'b0; end
            2'd2: begin r[0] = 1'b0; r[2] = 1'b1; end
            2'd3: begin r[0] = 1'b0; r[2] = 1'b0; end
        endcase
        return r;
    endfunction

    function automatic logic [1:0] tree_pick(input logic [2:0] b);
        return b[0] ? (b[2] ? 2'd3 : 2'd2) : (b[1] ? 2'd1 : 2'd0);
    endfunction

    // ---------------- victim selection ----------------
    always_comb begin
        hit_any   = i_hit_valid && (|i_hit_way);
        hit_idx   = first_idx(i_hit_way);
        // forward a same-cycle hit into the fill's set so the hit way is
        // never the one evicted
        fill_base = plru[i_fill_set];
        if (hit_any && (i_hit_set == i_fill_set))
            fill_base = plru_upd(fill_base, hit_idx);
        victim_idx = (&i_way_valid) ? tree_pick(fill_base) : first_idx(~i_way_valid);
        fill_upd   = plru_upd(fill_base, victim_idx);
        accept     = (state == IDLE) && i_fill_valid;
    end

    // ---------------- PLRU state ----------------
    // The fill write lands after the hit write. For a shared set it already
    // contains the hit update, so both accesses are reflected.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            plru <= '0;
        end else if (i_flush) begin
            plru <= '0;
        end else begin
            if (hit_any)
                plru[i_hit_set] <= plru_upd(plru[i_hit_set], hit_idx);
            if (accept)
                plru[i_fill_set] <= fill_upd;
        end
    end

    // ---------------- fill datapath ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_set     <= '0;
            o_wr_data    <= '0;
            o_victim_way <= '0;
        end else if (accept) begin
            o_wr_set     <= i_fill_set;
            o_wr_data    <= i_fill_data;
            o_victim_way <= INPUTS'(4'b0001 << victim_idx);
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (i_fill_valid) state_nxt = WRITE;
            WRITE: state_nxt = IDLE;
        endcase
    end

    // o_wr_en decodes from state, so reset kills a write pulse immediately
    always_comb begin
        o_fill_ready = 1'b0;
        o_wr_en      = '0;
        case (state)
            IDLE:  o_fill_ready = 1'b1;
            WRITE: o_wr_en      = o_victim_way;
        endcase
    end

endmodule

// File: tb/tb_cache_way_fill_writer.sv
// ---------------------------------------------------------------------------
// tb_cache_way_fill_writer
//   Directed stimulus. Each accepted fill pushes its hand-computed write into
//   a queue. A monitor pops an entry on every write pulse and compares the way,
//   set, data, victim register and cycle.
// ---------------------------------------------------------------------------
module tb_cache_way_fill_writer;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_hit_valid;
    logic [3:0]  i_hit_set;
    logic [3:0]  i_hit_way;
    logic        i_fill_valid;
    logic        o_fill_ready;
    logic [3:0]  i_fill_set;
    logic [31:0] i_fill_data;
    logic [3:0]  i_way_valid;
    logic        i_flush;
    logic [3:0]  o_wr_en;
    logic [3:0]  o_wr_set;
    logic [31:0] o_wr_data;
    logic [3:0]  o_victim_way;

    cache_way_fill_writer #(.DATA_WIDTH(32), .INPUTS(4), .SETS(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_hit_valid(i_hit_valid), .i_hit_set(i_hit_set), .i_hit_way(i_hit_way),
        .i_fill_valid(i_fill_valid), .o_fill_ready(o_fill_ready),
        .i_fill_set(i_fill_set), .i_fill_data(i_fill_data),
        .i_way_valid(i_way_valid), .i_flush(i_flush),
        .o_wr_en(o_wr_en), .o_wr_set(o_wr_set), .o_wr_data(o_wr_data),
        .o_victim_way(o_victim_way)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  way;
        logic [3:0]  set;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: every write pulse must match the oldest outstanding fill
    always @(negedge i_clk) begin
        if (i_rst_n === 1'b1 && o_wr_en !== 4'b0000) begin
            if (q.size() == 0) begin
                check("unexpected_write", {28'd0, o_wr_en}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("wr_en",      {28'd0, o_wr_en},      {28'd0, e.way});
                check("wr_set",     {28'd0, o_wr_set},     {28'd0, e.set});
                check("wr_data",    o_wr_data,             e.data);
                check("victim_way", {28'd0, o_victim_way}, {28'd0, e.way});
                check("wr_cycle",   cyc,                   e.cyc);
            end
        end
    end

    // One fill. Optional hit/flush are driven in the same cycle as the first
    // offer. The fill is held until ready, and the expected write is pushed
    // at accept.
    task automatic do_fill(input logic [3:0] set, input logic [31:0] data,
                           input logic [3:0] vv, input logic [3:0] exp_way,
                           input logic hv, input logic [3:0] hset,
                           input logic [3:0] hway, input logic fl);
        int n;
        exp_t e;
        n = 0;
        @(negedge i_clk);
        i_fill_valid = 1'b1; i_fill_set = set; i_fill_data = data; i_way_valid = vv;
        i_hit_valid = hv; i_hit_set = hset; i_hit_way = hway; i_flush = fl;
        while (o_fill_ready !== 1'b1 && n < 8) begin
            @(negedge i_clk);
            n++;
        end
        if (o_fill_ready !== 1'b1) begin
            check("fill_ready_timeout", {31'd0, o_fill_ready}, 32'd1);
        end else begin
            e.way = exp_way; e.set = set; e.data = data; e.cyc = cyc + 1;
            q.push_back(e);
        end
        @(negedge i_clk);
        i_fill_valid = 1'b0; i_hit_valid = 1'b0; i_hit_way = 4'd0; i_flush = 1'b0;
    endtask

    task automatic do_hit(input logic [3:0] set, input logic [3:0] way);
        @(negedge i_clk);
        i_hit_valid = 1'b1; i_hit_set = set; i_hit_way = way;
    endtask

    task automatic do_flush();
        @(negedge i_clk);
        i_flush = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (expected to finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0;
        i_hit_valid = 1'b0; i_hit_set = '0; i_hit_way = '0;
        i_fill_valid = 1'b0; i_fill_set = '0; i_fill_data = '0;
        i_way_valid = 4'hF; i_flush = 1'b0;

        // reset state
        #3;
        check("rst_wr_en",      {28'd0, o_wr_en},      32'd0);
        check("rst_wr_set",     {28'd0, o_wr_set},     32'd0);
        check("rst_wr_data",    o_wr_data,             32'd0);
        check("rst_victim",     {28'd0, o_victim_way}, 32'd0);
        check("rst_fill_ready", {31'd0, o_fill_ready}, 32'd1);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        // tree walk on a fresh set: 0001, 0100, 0010, 1000
        do_fill(4'd3, 32'h1000_0001, 4'hF, 4'b0001, 1'b0, 4'd0, 4'd0, 1'b0);
        do_fill(4'd3, 32'h1000_0002, 4'hF, 4'b0100, 1'b0, 4'd0, 4'd0, 1'b0);
        do_fill(4'd3, 32'h1000_0003, 4'hF, 4'b0010, 1'b0, 4'd0, 4'd0, 1'b0);
        do_fill(4'd3, 32'h1000_0004, 4'hF, 4'b1000, 1'b0, 4'd0, 4'd0, 1'b0);

        // set 7: hit way0 (b0=1,b1=1). Invalid way2 is then filled first,
        // which leaves b0=0 and b1=1, so the tree walk picks way1.
        do_hit(4'd7, 4'b0001);
        do_fill(4'd7, 32'hDEAD_BEEF, 4'b1011, 4'b0100, 1'b0, 4'd0, 4'd0, 1'b0);
        do_fill(4'd7, 32'h0000_7777, 4'hF,    4'b0010, 1'b0, 4'd0, 4'd0, 1'b0);

        // hit then next-cycle fill (set 5), and same-cycle forwarded (set 9)
        do_hit(4'd5, 4'b0001);
        do_fill(4'd5, 32'h5555_0000, 4'hF, 4'b0100, 1'b0, 4'd0, 4'd0, 1'b0);
        do_fill(4'd9, 32'h9999_0000, 4'hF, 4'b0100, 1'b1, 4'd9, 4'b0001, 1'b0);

        // multi-hot hit uses lowest bit (way1), zero hit way does nothing
        do_hit(4'd10, 4'b1010);
        do_fill(4'd10, 32'hAAAA_0000, 4'hF, 4'b0100, 1'b0, 4'd0, 4'd0, 1'b0);
        do_hit(4'd11, 4'b0000);
        do_fill(4'd11, 32'hBBBB_0000, 4'hF, 4'b0001, 1'b0, 4'd0, 4'd0, 1'b0);

        // fill held valid 4 cycles: ready 1,0,1,0 and exactly two writes
        begin
            logic [3:0] rdy_exp;
            exp_t e;
            rdy_exp = 4'b0101;
            @(negedge i_clk);
            i_fill_valid = 1'b1; i_fill_set = 4'd12; i_fill_data = 32'hC0C0_C0C0;
            i_way_valid = 4'hF;
            for (int k = 0; k < 4; k++) begin
                if (k > 0) @(negedge i_clk);
                check("held_ready", {31'd0, o_fill_ready}, {31'd0, rdy_exp[k]});
                if (o_fill_ready === 1'b1) begin
                    e.way = (k == 0) ? 4'b0001 : 4'b0100;
                    e.set = 4'd12; e.data = 32'hC0C0_C0C0; e.cyc = cyc + 1;
                    q.push_back(e);
                end
            end
            @(negedge i_clk);
            i_fill_valid = 1'b0;
        end

        // flush. Set 3 is at 000 after the walk; one fill moves it to 110.
        do_fill(4'd3, 32'h3000_0001, 4'hF, 4'b0001, 1'b0, 4'd0, 4'd0, 1'b0);
        // fill in the flush cycle uses pre-flush state (way2); flush drops its update
        do_fill(4'd3, 32'h3000_0002, 4'hF, 4'b0100, 1'b0, 4'd0, 4'd0, 1'b1);
        do_fill(4'd3, 32'h3000_0003, 4'hF, 4'b0001, 1'b0, 4'd0, 4'd0, 1'b0);
        do_flush();
        do_fill(4'd3, 32'h3000_0004, 4'hF, 4'b0001, 1'b0, 4'd0, 4'd0, 1'b0);

        // set 3 is 110 again. Reset in the middle of a write.
        begin
            exp_t e;
            @(negedge i_clk);
            i_fill_valid = 1'b1; i_fill_set = 4'd2; i_fill_data = 32'h2222_2222;
            i_way_valid = 4'hF;
            check("pre_rst_ready", {31'd0, o_fill_ready}, 32'd1);
            e.way = 4'b0001; e.set = 4'd2; e.data = 32'h2222_2222; e.cyc = cyc + 1;
            q.push_back(e);
            @(negedge i_clk);
            i_fill_valid = 1'b0;
            #1;
            check("mid_write_wr_en", {28'd0, o_wr_en}, 32'd1);
            i_rst_n = 1'b0;
            #1;
            check("rst_abort_wr_en",  {28'd0, o_wr_en},      32'd0);
            check("rst_abort_victim", {28'd0, o_victim_way}, 32'd0);
            check("rst_abort_ready",  {31'd0, o_fill_ready}, 32'd1);
            #1;
            i_rst_n = 1'b1;
        end
        // PLRU was cleared by reset: set 3 goes back to way0
        do_fill(4'd3, 32'h3000_0005, 4'hF, 4'b0001, 1'b0, 4'd0, 4'd0, 1'b0);

        repeat (4) @(negedge i_clk);
        check("no_lost_fill", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
